// File: rtl/ddr2_cmd_monitor_if.sv
// Observed DDR2 command/address bus plus the monitor's decoded results.
// master: the side driving the pads; slave: the passive monitor.
interface ddr2_cmd_monitor_if #(
  parameter int ROW_W = 14,
  parameter int BA_W  = 3,
  parameter int CS_W  = 1
);
  localparam int NBANK = 2 ** BA_W;

  logic [ROW_W-1:0] ddr_address;
  logic [BA_W-1:0]  ddr_ba;
  logic             ddr_ras_l;
  logic             ddr_cas_l;
  logic             ddr_we_l;
  logic [CS_W-1:0]  ddr_cs_l;
  logic             ddr_cke;
  logic             err_clr;

  logic             cmd_valid;
  logic [2:0]       cmd_code;
  logic [BA_W-1:0]  cmd_bank;
  logic [ROW_W-1:0] cmd_addr;
  logic [NBANK-1:0] bank_open;
  logic [5:0]       err_pulse;
  logic [5:0]       err_status;

  modport master (
    output ddr_address, ddr_ba, ddr_ras_l, ddr_cas_l, ddr_we_l, ddr_cs_l, ddr_cke, err_clr,
    input  cmd_valid, cmd_code, cmd_bank, cmd_addr, bank_open, err_pulse, err_status
  );

  modport slave (
    input  ddr_address, ddr_ba, ddr_ras_l, ddr_cas_l, ddr_we_l, ddr_cs_l, ddr_cke, err_clr,
    output cmd_valid, cmd_code, cmd_bank, cmd_addr, bank_open, err_pulse, err_status
  );
endinterface

// File: rtl/ddr2_cmd_monitor.sv
// Passive DDR2 command decoder with per-bank open/row tracking and protocol error flags.
// Define DDR2_CMD_MON_TIMING_CHK_EN to build the tRCD/tRP checks (err bits 3 and 4).
module ddr2_cmd_monitor #(
  parameter int ROW_W = 14,
  parameter int BA_W  = 3,
  parameter int CS_W  = 1,
  parameter int TRCD  = 4,
  parameter int TRP   = 4
) (
  input  logic            clk0,
  input  logic            rst0,
  ddr2_cmd_monitor_if.slave bus
);
  localparam int NBANK = 2 ** BA_W;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;
  localparam logic [2:0] CMD_REF  = 3'd6;
  localparam logic [2:0] CMD_MRS  = 3'd7;

  logic             w_active;
  logic [2:0]       w_code;
  logic             w_illegal;
  logic             w_act;
  logic             w_rdwr;
  logic             w_pre;
  logic             w_prea;
  logic             w_refmrs;
  logic [NBANK-1:0] w_open;
  logic [NBANK-1:0] w_trcd_busy;
  logic [NBANK-1:0] w_trp_busy;
  logic [5:0]       w_err;

  logic             r_cmd_valid;
  logic [2:0]       r_cmd_code;
  logic [BA_W-1:0]  r_cmd_bank;
  logic [ROW_W-1:0] r_cmd_addr;
  logic [5:0]       r_err_pulse;
  logic [5:0]       r_err_status;

  assign w_active = bus.ddr_cke & ~bus.ddr_cs_l[0];

  always_comb begin
    w_code    = CMD_NOP;
    w_illegal = 1'b0;
    if (w_active) begin
      case ({bus.ddr_ras_l, bus.ddr_cas_l, bus.ddr_we_l})
        3'b000:  w_code = CMD_MRS;
        3'b001:  w_code = CMD_REF;
        3'b010:  w_code = bus.ddr_address[10] ? CMD_PREA : CMD_PRE;
        3'b011:  w_code = CMD_ACT;
        3'b100:  w_code = CMD_WR;
        3'b101:  w_code = CMD_RD;
        3'b110:  w_illegal = 1'b1;
        default: w_code = CMD_NOP;
      endcase
    end
  end

  assign w_act    = (w_code == CMD_ACT);
  assign w_rdwr   = (w_code == CMD_RD) || (w_code == CMD_WR);
  assign w_pre    = (w_code == CMD_PRE);
  assign w_prea   = (w_code == CMD_PREA);
  assign w_refmrs = (w_code == CMD_REF) || (w_code == CMD_MRS);

  genvar gi;
  generate
    for (gi = 0; gi < NBANK; gi++) begin : g_bank
      logic             w_hit;
      logic             r_open;
      logic [ROW_W-1:0] r_row;

      assign w_hit = (bus.ddr_ba == BA_W'(gi));

      // An ACT to an already-open bank simply reopens it with the new row.
      always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
          r_open <= 1'b0;
          r_row  <= '0;
        end else if (w_act && w_hit) begin
          r_open <= 1'b1;
          r_row  <= bus.ddr_address;
        end else if ((w_pre && w_hit) || w_prea) begin
          r_open <= 1'b0;
        end
      end

      assign w_open[gi] = r_open;

`ifdef DDR2_CMD_MON_TIMING_CHK_EN
      localparam int TMAX  = (TRCD > TRP) ? TRCD : TRP;
      localparam int CNT_W = (TMAX > 1) ? $clog2(TMAX) : 1;

      logic [CNT_W-1:0] r_trcd_cnt;
      logic [CNT_W-1:0] r_trp_cnt;

      // Counters hold cycles still to wait; zero means the next command is legal.
      always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
          r_trcd_cnt <= '0;
          r_trp_cnt  <= '0;
        end else begin
          if (w_act && w_hit)
            r_trcd_cnt <= CNT_W'(TRCD - 1);
          else if (r_trcd_cnt != '0)
            r_trcd_cnt <= r_trcd_cnt - CNT_W'(1);

          if ((w_pre && w_hit) || w_prea)
            r_trp_cnt <= CNT_W'(TRP - 1);
          else if (r_trp_cnt != '0)
            r_trp_cnt <= r_trp_cnt - CNT_W'(1);
        end
      end

      assign w_trcd_busy[gi] = (r_trcd_cnt != '0);
      assign w_trp_busy[gi]  = (r_trp_cnt != '0);
`else
      assign w_trcd_busy[gi] = 1'b0;
      assign w_trp_busy[gi]  = 1'b0;
`endif
    end
  endgenerate

  // A RD/WR to a closed bank reports only the closed-bank error, never tRCD.
  assign w_err[0] = w_act & w_open[bus.ddr_ba];
  assign w_err[1] = w_rdwr & ~w_open[bus.ddr_ba];
  assign w_err[2] = w_refmrs & (|w_open);
  assign w_err[3] = w_rdwr & w_open[bus.ddr_ba] & w_trcd_busy[bus.ddr_ba];
  assign w_err[4] = w_act & w_trp_busy[bus.ddr_ba];
  assign w_err[5] = w_illegal;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_cmd_valid  <= 1'b0;
      r_cmd_code   <= CMD_NOP;
      r_cmd_bank   <= '0;
      r_cmd_addr   <= '0;
      r_err_pulse  <= '0;
      r_err_status <= '0;
    end else begin
      r_cmd_valid <= (w_code != CMD_NOP);
      r_cmd_code  <= w_code;
      if (w_code != CMD_NOP) begin
        r_cmd_bank <= bus.ddr_ba;
        r_cmd_addr <= bus.ddr_address;
      end
      r_err_pulse  <= w_err;
      // A fresh error in the clearing cycle survives the clear.
      r_err_status <= (bus.err_clr ? 6'd0 : r_err_status) | w_err;
    end
  end

  assign bus.cmd_valid  = r_cmd_valid;
  assign bus.cmd_code   = r_cmd_code;
  assign bus.cmd_bank   = r_cmd_bank;
  assign bus.cmd_addr   = r_cmd_addr;
  assign bus.bank_open  = w_open;
  assign bus.err_pulse  = r_err_pulse;
  assign bus.err_status = r_err_status;

endmodule

// File: tb/tb_ddr2_cmd_monitor.sv
// Bench for ddr2_cmd_monitor: directed vector table, reset corner case, and
// randomized traffic checked against a timestamp-based protocol model.
module tb_ddr2_cmd_monitor;
  localparam int ROW_W = 14;
  localparam int BA_W  = 3;
  localparam int CS_W  = 1;
  localparam int TRCD  = 4;
  localparam int TRP   = 4;
  localparam int NBANK = 8;

`ifdef DDR2_CMD_MON_TIMING_CHK_EN
  localparam bit TIMING = 1'b1;
`else
  localparam bit TIMING = 1'b0;
`endif
  localparam logic [5:0] EMASK = TIMING ? 6'h3F : 6'h27;

  localparam logic [2:0] E_MRS = 3'b000;
  localparam logic [2:0] E_REF = 3'b001;
  localparam logic [2:0] E_PRE = 3'b010;
  localparam logic [2:0] E_ACT = 3'b011;
  localparam logic [2:0] E_WR  = 3'b100;
  localparam logic [2:0] E_RD  = 3'b101;
  localparam logic [2:0] E_ILL = 3'b110;
  localparam logic [2:0] E_NOP = 3'b111;

  typedef struct {
    string       name;
    logic        cke;
    logic        cs;
    logic [2:0]  rcw;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic        clr;
    logic        e_valid;
    logic [2:0]  e_code;
    logic [7:0]  e_open;
    logic [5:0]  e_pulse;
    logic [5:0]  e_status;
  } vec_t;

  logic clk0 = 1'b0;
  logic rst0 = 1'b1;
  always #5 clk0 = ~clk0;

  ddr2_cmd_monitor_if #(.ROW_W(ROW_W), .BA_W(BA_W), .CS_W(CS_W)) bus ();

  ddr2_cmd_monitor #(
    .ROW_W(ROW_W), .BA_W(BA_W), .CS_W(CS_W), .TRCD(TRCD), .TRP(TRP)
  ) dut (
    .clk0(clk0),
    .rst0(rst0),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[$];

  // Reference model state: open flags plus the cycle of the last ACT/PRE per bank.
  bit         m_open[NBANK];
  int         m_act_cyc[NBANK];
  int         m_pre_cyc[NBANK];
  logic [5:0] m_status;
  int         m_cyc;

  function automatic vec_t mk(string name, logic cke, logic cs, logic [2:0] rcw, logic [2:0] ba,
                              logic [13:0] addr, logic clr, logic v, logic [2:0] code,
                              logic [7:0] open, logic [5:0] pulse, logic [5:0] status);
    vec_t t;
    t.name = name; t.cke = cke; t.cs = cs; t.rcw = rcw; t.ba = ba; t.addr = addr; t.clr = clr;
    t.e_valid = v; t.e_code = code; t.e_open = open; t.e_pulse = pulse; t.e_status = status;
    return t;
  endfunction

  task automatic drive(input logic cke, input logic cs, input logic [2:0] rcw, input logic [2:0] ba,
                       input logic [13:0] addr, input logic clr);
    bus.ddr_cke     = cke;
    bus.ddr_cs_l[0] = cs;
    {bus.ddr_ras_l, bus.ddr_cas_l, bus.ddr_we_l} = rcw;
    bus.ddr_ba      = ba;
    bus.ddr_address = addr;
    bus.err_clr     = clr;
  endtask

  task automatic tick;
    @(posedge clk0);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic [2:0] ec, input logic [2:0] eb,
                       input logic [13:0] ea, input logic [7:0] eo, input logic [5:0] ep,
                       input logic [5:0] es);
    logic bad;
    n_checks++;
    bad = (bus.cmd_valid !== ev) || (bus.cmd_code !== ec) || (bus.bank_open !== eo) ||
          (bus.err_pulse !== ep) || (bus.err_status !== es);
    if (ev && ((bus.cmd_bank !== eb) || (bus.cmd_addr !== ea))) bad = 1'b1;
    if (bad) begin
      n_errors++;
      $display("FAIL %s: got v=%b code=%0d bank=%0d addr=%h open=%h pulse=%h status=%h ; want v=%b code=%0d bank=%0d addr=%h open=%h pulse=%h status=%h",
               name, bus.cmd_valid, bus.cmd_code, bus.cmd_bank, bus.cmd_addr, bus.bank_open,
               bus.err_pulse, bus.err_status, ev, ec, eb, ea, eo, ep, es);
    end else begin
      $display("ok   %s: v=%b code=%0d open=%h pulse=%h status=%h",
               name, bus.cmd_valid, bus.cmd_code, bus.bank_open, bus.err_pulse, bus.err_status);
    end
  endtask

  task automatic model_reset;
    for (int b = 0; b < NBANK; b++) begin
      m_open[b]    = 1'b0;
      m_act_cyc[b] = -1000;
      m_pre_cyc[b] = -1000;
    end
    m_status = '0;
    m_cyc    = 0;
  endtask

  task automatic model_step(input logic cke, input logic cs, input logic [2:0] rcw,
                            input logic [2:0] ba, input logic [13:0] addr, input logic clr,
                            output logic ev, output logic [2:0] ec, output logic [7:0] eo,
                            output logic [5:0] ep, output logic [5:0] es);
    logic [2:0] code;
    logic [5:0] err;
    bit         any_open;
    code = 3'd0;
    err  = '0;
    any_open = 1'b0;
    for (int b = 0; b < NBANK; b++) any_open |= m_open[b];
    if (cke && !cs) begin
      case (rcw)
        E_MRS: code = 3'd7;
        E_REF: code = 3'd6;
        E_PRE: code = addr[10] ? 3'd5 : 3'd4;
        E_ACT: code = 3'd1;
        E_WR:  code = 3'd3;
        E_RD:  code = 3'd2;
        E_ILL: err[5] = 1'b1;
        default: code = 3'd0;
      endcase
    end
    case (code)
      3'd1: begin
        err[0] = m_open[ba];
        err[4] = TIMING && ((m_cyc - m_pre_cyc[ba]) < TRP);
        m_open[ba] = 1'b1;
        m_act_cyc[ba] = m_cyc;
      end
      3'd2, 3'd3: begin
        if (!m_open[ba]) err[1] = 1'b1;
        else err[3] = TIMING && ((m_cyc - m_act_cyc[ba]) < TRCD);
      end
      3'd4: begin
        m_open[ba] = 1'b0;
        m_pre_cyc[ba] = m_cyc;
      end
      3'd5: begin
        for (int b = 0; b < NBANK; b++) begin
          m_open[b] = 1'b0;
          m_pre_cyc[b] = m_cyc;
        end
      end
      3'd6, 3'd7: err[2] = any_open;
      default: ;
    endcase
    m_status = (clr ? 6'd0 : m_status) | err;
    ev = (code != 3'd0);
    ec = code;
    ep = err;
    es = m_status;
    for (int b = 0; b < NBANK; b++) eo[b] = m_open[b];
    m_cyc++;
  endtask

  initial begin
    logic        ev;
    logic [2:0]  ec;
    logic [7:0]  eo;
    logic [5:0]  ep;
    logic [5:0]  es;
    logic        r_cke, r_cs, r_clr;
    logic [2:0]  r_rcw, r_ba;
    logic [13:0] r_addr;

    // name, cke, cs_l, cmd, ba, addr, clr  |  valid, code, bank_open, err_pulse, err_status
    vecs.push_back(mk("act_b2_row123",  1, 0, E_ACT, 2, 14'h123, 0, 1, 1, 8'h04, 6'h00, 6'h00));
    vecs.push_back(mk("idle1",          1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h04, 6'h00, 6'h00));
    vecs.push_back(mk("idle2",          1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h04, 6'h00, 6'h00));
    vecs.push_back(mk("idle3",          1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h04, 6'h00, 6'h00));
    vecs.push_back(mk("rd_b2_col10",    1, 0, E_RD,  2, 14'h010, 0, 1, 2, 8'h04, 6'h00, 6'h00));
    vecs.push_back(mk("pre_b2",         1, 0, E_PRE, 2, 14'h000, 0, 1, 4, 8'h00, 6'h00, 6'h00));
    vecs.push_back(mk("act_b0",         1, 0, E_ACT, 0, 14'h055, 0, 1, 1, 8'h01, 6'h00, 6'h00));
    vecs.push_back(mk("idle_trcd",      1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h01, 6'h00, 6'h00));
    vecs.push_back(mk("rd_b0_k2_trcd",  1, 0, E_RD,  0, 14'h020, 0, 1, 2, 8'h01, 6'h08, 6'h08));
    vecs.push_back(mk("clr_after_trcd", 1, 0, E_NOP, 0, 14'h000, 1, 0, 0, 8'h01, 6'h00, 6'h00));
    vecs.push_back(mk("pre_b1_closed",  1, 0, E_PRE, 1, 14'h000, 0, 1, 4, 8'h01, 6'h00, 6'h00));
    vecs.push_back(mk("idle_trp_a",     1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h01, 6'h00, 6'h00));
    vecs.push_back(mk("idle_trp_b",     1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h01, 6'h00, 6'h00));
    vecs.push_back(mk("act_b1_k3_trp",  1, 0, E_ACT, 1, 14'h077, 0, 1, 1, 8'h03, 6'h10, 6'h10));
    vecs.push_back(mk("pre_b1",         1, 0, E_PRE, 1, 14'h000, 0, 1, 4, 8'h01, 6'h00, 6'h10));
    vecs.push_back(mk("idle_trp_c",     1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h01, 6'h00, 6'h10));
    vecs.push_back(mk("idle_trp_d",     1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h01, 6'h00, 6'h10));
    vecs.push_back(mk("idle_trp_e",     1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h01, 6'h00, 6'h10));
    vecs.push_back(mk("act_b1_k4_ok",   1, 0, E_ACT, 1, 14'h078, 0, 1, 1, 8'h03, 6'h00, 6'h10));
    vecs.push_back(mk("prea_with_clr",  1, 0, E_PRE, 0, 14'h400, 1, 1, 5, 8'h00, 6'h00, 6'h00));
    vecs.push_back(mk("idle_p1",        1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h00, 6'h00, 6'h00));
    vecs.push_back(mk("idle_p2",        1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h00, 6'h00, 6'h00));
    vecs.push_back(mk("idle_p3",        1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h00, 6'h00, 6'h00));
    vecs.push_back(mk("act_b0_again",   1, 0, E_ACT, 0, 14'h100, 0, 1, 1, 8'h01, 6'h00, 6'h00));
    vecs.push_back(mk("act_b3",         1, 0, E_ACT, 3, 14'h200, 0, 1, 1, 8'h09, 6'h00, 6'h00));
    vecs.push_back(mk("ref_banks_open", 1, 0, E_REF, 0, 14'h000, 0, 1, 6, 8'h09, 6'h04, 6'h04));
    vecs.push_back(mk("prea",           1, 0, E_PRE, 0, 14'h400, 0, 1, 5, 8'h00, 6'h00, 6'h04));
    vecs.push_back(mk("idle_q1",        1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h00, 6'h00, 6'h04));
    vecs.push_back(mk("idle_q2",        1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h00, 6'h00, 6'h04));
    vecs.push_back(mk("idle_q3",        1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h00, 6'h00, 6'h04));
    vecs.push_back(mk("ref_all_closed", 1, 0, E_REF, 0, 14'h000, 0, 1, 6, 8'h00, 6'h00, 6'h04));
    vecs.push_back(mk("clr_status",     1, 0, E_NOP, 0, 14'h000, 1, 0, 0, 8'h00, 6'h00, 6'h00));
    vecs.push_back(mk("wr_b5_closed",   1, 0, E_WR,  5, 14'h007, 0, 1, 3, 8'h00, 6'h02, 6'h02));
    vecs.push_back(mk("illegal_hhl",    1, 0, E_ILL, 0, 14'h000, 0, 0, 0, 8'h00, 6'h20, 6'h22));
    vecs.push_back(mk("pulse_drops",    1, 0, E_NOP, 0, 14'h000, 0, 0, 0, 8'h00, 6'h00, 6'h22));
    vecs.push_back(mk("cke0_act",       0, 0, E_ACT, 4, 14'h011, 0, 0, 0, 8'h00, 6'h00, 6'h22));
    vecs.push_back(mk("cs1_act",        1, 1, E_ACT, 4, 14'h012, 0, 0, 0, 8'h00, 6'h00, 6'h22));
    vecs.push_back(mk("act_b6",         1, 0, E_ACT, 6, 14'h0AA, 0, 1, 1, 8'h40, 6'h00, 6'h22));
    vecs.push_back(mk("act_b6_open_clr",1, 0, E_ACT, 6, 14'h0BB, 1, 1, 1, 8'h40, 6'h01, 6'h01));
    vecs.push_back(mk("mrs_bank_open",  1, 0, E_MRS, 0, 14'h000, 0, 1, 7, 8'h40, 6'h04, 6'h05));
    vecs.push_back(mk("cke0_illegal",   0, 0, E_ILL, 0, 14'h000, 0, 0, 0, 8'h40, 6'h00, 6'h05));

    drive(1, 0, E_NOP, 0, 14'h000, 0);
    rst0 = 1'b1;
    tick();
    tick();
    check("reset_state", 0, 0, 0, 14'h000, 8'h00, 6'h00, 6'h00);
    rst0 = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cke, vecs[i].cs, vecs[i].rcw, vecs[i].ba, vecs[i].addr, vecs[i].clr);
      tick();
      check(vecs[i].name, vecs[i].e_valid, vecs[i].e_code, vecs[i].ba, vecs[i].addr,
            vecs[i].e_open, vecs[i].e_pulse & EMASK, vecs[i].e_status & EMASK);
    end

    // Asynchronous reset in the middle of a cycle must drop all state at once.
    drive(1, 0, E_ACT, 1, 14'h033, 0);
    tick();
    check("act_b1_pre_reset", 1, 1, 1, 14'h033, 8'h42, 6'h00, 6'h05 & EMASK);
    drive(1, 0, E_NOP, 0, 14'h000, 0);
    #2 rst0 = 1'b1;
    #1 check("async_reset_mid", 0, 0, 0, 14'h000, 8'h00, 6'h00, 6'h00);
    tick();
    rst0 = 1'b0;
    drive(1, 0, E_RD, 1, 14'h044, 0);
    tick();
    check("rd_b1_after_reset", 1, 2, 1, 14'h044, 8'h00, 6'h02, 6'h02);

    // Randomized traffic against the reference model, from a clean reset.
    drive(1, 0, E_NOP, 0, 14'h000, 0);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    model_reset();
    for (int i = 0; i < 1000; i++) begin
      r_cke  = ($urandom_range(0, 15) != 0);
      r_cs   = ($urandom_range(0, 15) == 0);
      r_rcw  = ($urandom_range(0, 9) < 4) ? E_NOP : 3'($urandom_range(0, 7));
      r_ba   = 3'($urandom_range(0, 3));
      r_addr = 14'($urandom);
      r_clr  = ($urandom_range(0, 15) == 0);
      drive(r_cke, r_cs, r_rcw, r_ba, r_addr, r_clr);
      model_step(r_cke, r_cs, r_rcw, r_ba, r_addr, r_clr, ev, ec, eo, ep, es);
      tick();
      check($sformatf("rand_%0d", i), ev, ec, r_ba, r_addr, eo, ep, es);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
